// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle main FSM and the datapath.
// Handshake: the controller raises MemRead or MemWrite together with AdrSrc
// and holds all three stable on every cycle until it samples mem_ready=1;
// the access completes on that clock edge. mem_ready is ignored while no
// request strobe is high.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       AluFunctEn;
  logic [1:0] ResultSrc;

  // Controller side.
  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, AluFunctEn, ResultSrc
  );

  // Datapath side.
  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, AluFunctEn, ResultSrc
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V core. Sequences fetch, decode,
// execute, memory and write-back over the shared ALU / register file /
// unified memory port, flags unsupported opcodes and counts retirements.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus,
  output logic                 instr_done,
  output logic                 illegal,
  output logic [3:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Mux select encodings used by the datapath.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEMDAT = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Every datapath control in one bundle so the decode has a single default.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       alu_funct_en;
    logic [1:0] result_src;
    logic       done;
  } ctrl_t;

  state_t               state;
  state_t               state_next;
  ctrl_t                ctrl;
  logic                 illegal_q;
  logic [INSTRET_W-1:0] instret_q;

  logic is_r;
  logic is_i;
  logic is_lw;
  logic is_sw;
  logic is_beq;

  assign is_r   = (bus.opcode == OP_R);
  assign is_i   = (bus.opcode == OP_I);
  assign is_lw  = (bus.opcode == OP_LW);
  assign is_sw  = (bus.opcode == OP_SW);
  assign is_beq = (bus.opcode == OP_BEQ);

  // State register; reset lands in FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. TRAP is absorbing; only reset leaves it.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw) begin
          state_next = S_MEMADR;
        end else if (is_r) begin
          state_next = S_EXECR;
        end else if (is_i) begin
          state_next = S_EXECI;
        end else if (is_beq) begin
          state_next = S_BEQ;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_MEMADR:   state_next = is_lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      // Unused encodings recover to a clean fetch.
      default:    state_next = S_FETCH;
    endcase
  end

  // Output decode from the state register, gated only by mem_ready/zero.
  // Reset forces every strobe and select to zero in the same cycle so a
  // pending memory request or write-back is dropped immediately.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read   = 1'b1;
          ctrl.adr_src    = 1'b0;
          ctrl.alu_src_a  = SRCA_PC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.result_src = RES_ALURES;
          ctrl.ir_write   = bus.mem_ready;
          ctrl.pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          // OldPC + imm lands in ALUOut as the branch target.
          ctrl.alu_src_a = SRCA_OLDPC;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMADR: begin
          ctrl.alu_src_a = SRCA_REGA;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMREAD: begin
          ctrl.mem_read = 1'b1;
          ctrl.adr_src  = 1'b1;
        end
        S_MEMWB: begin
          ctrl.result_src = RES_MEMDAT;
          ctrl.reg_write  = 1'b1;
          ctrl.done       = 1'b1;
        end
        S_MEMWRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.adr_src   = 1'b1;
          ctrl.done      = bus.mem_ready;
        end
        S_EXECR: begin
          ctrl.alu_src_a    = SRCA_REGA;
          ctrl.alu_src_b    = SRCB_REGB;
          ctrl.alu_op       = ALUOP_RTYP;
          ctrl.alu_funct_en = 1'b1;
        end
        S_EXECI: begin
          ctrl.alu_src_a    = SRCA_REGA;
          ctrl.alu_src_b    = SRCB_IMM;
          ctrl.alu_op       = ALUOP_ADD;
          ctrl.alu_funct_en = 1'b1;
        end
        S_ALUWB: begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.reg_write  = 1'b1;
          ctrl.done       = 1'b1;
        end
        S_BEQ: begin
          // PC takes the ALUOut branch target only when rs1 == rs2.
          ctrl.alu_src_a  = SRCA_REGA;
          ctrl.alu_src_b  = SRCB_REGB;
          ctrl.alu_op     = ALUOP_SUB;
          ctrl.result_src = RES_ALUOUT;
          ctrl.pc_write   = bus.zero;
          ctrl.done       = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  // Sticky illegal flag, raised on the transition into TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state == S_DECODE && state_next == S_TRAP) begin
      illegal_q <= 1'b1;
    end
  end

  // Retired-instruction counter; wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (ctrl.done) begin
      instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.AluFunctEn = ctrl.alu_funct_en;
  assign bus.ResultSrc  = ctrl.result_src;

  assign instr_done = ctrl.done;
  assign illegal    = illegal_q;
  assign state_o    = state;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction runs,
// a per-cycle expected-output queue built from instruction-level rules,
// and literal pins on sequences, counts and flags.
module tb_multicycle_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw;
    logic        adr;
    logic        mr;
    logic        mw;
    logic        irw;
    logic        rw;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  op;
    logic        fe;
    logic [1:0]  rs;
    logic        done;
    logic        ill;
    logic [31:0] instret;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_done;
  logic        illegal;
  logic [3:0]  state_o;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.INSTRET_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state_o    (state_o),
    .instret    (instret)
  );

  // ---------------- scoreboard state ----------------
  exp_t        exp_q[$];
  logic [3:0]  st_log[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_inst = '0;
  logic        m_ill = 1'b0;

  // Expected outputs of one cycle, straight from the state output table.
  function automatic exp_t spec_outputs(input logic [3:0] st, input logic rst,
                                        input logic mr, input logic z);
    exp_t e;
    e = '0;
    e.st = st;
    if (!rst) begin
      case (st)
        4'd0: begin e.mr = 1; e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
        4'd1: begin e.sa = 2'b01; e.sb = 2'b01; end
        4'd2: begin e.sa = 2'b10; e.sb = 2'b01; end
        4'd3: begin e.mr = 1; e.adr = 1; end
        4'd4: begin e.rs = 2'b01; e.rw = 1; e.done = 1; end
        4'd5: begin e.mw = 1; e.adr = 1; e.done = mr; end
        4'd6: begin e.sa = 2'b10; e.op = 2'b10; e.fe = 1; end
        4'd7: begin e.sa = 2'b10; e.sb = 2'b01; e.fe = 1; end
        4'd8: begin e.rw = 1; e.done = 1; end
        4'd9: begin e.sa = 2'b10; e.op = 2'b01; e.pcw = z; e.done = 1; end
        default: e = e;
      endcase
    end
    return e;
  endfunction

  function automatic exp_t sample_dut();
    exp_t g;
    g.st = state_o; g.pcw = bus.PCWrite; g.adr = bus.AdrSrc;
    g.mr = bus.MemRead; g.mw = bus.MemWrite; g.irw = bus.IRWrite;
    g.rw = bus.RegWrite; g.sa = bus.ALUSrcA; g.sb = bus.ALUSrcB;
    g.op = bus.ALUOp; g.fe = bus.AluFunctEn; g.rs = bus.ResultSrc;
    g.done = instr_done; g.ill = illegal; g.instret = instret;
    return g;
  endfunction

  // Compare process: every queued cycle is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t g;
      e = exp_q.pop_front();
      g = sample_dut();
      st_log.push_back(state_o);
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL cycle_outputs t=%0t state exp=%0d got=%0d fields got=%h exp=%h",
                 $time, e.st, g.st, g, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, queue the expectation for the current
  // state, advance the model across the edge.
  task automatic cycle(input logic [3:0] st, input logic rst, input logic mr,
                       input logic z, input logic [6:0] opc);
    exp_t e;
    reset = rst;
    bus.mem_ready = mr;
    bus.zero = z;
    bus.opcode = opc;
    if (st == 4'd15) m_ill = 1'b1;
    e = spec_outputs(st, rst, mr, z);
    e.ill = m_ill;
    e.instret = m_inst;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      m_inst = '0;
      m_ill = 1'b0;
    end else if (e.done) begin
      m_inst = m_inst + 32'd1;
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One whole instruction: fw / mw cycles of mem_ready=0 in FETCH / memory.
  task automatic run_instr(input logic [6:0] opc, input logic z, input int fw, input int mw);
    for (int i = 0; i < fw; i++) cycle(4'd0, 1'b0, 1'b0, rnd(), opc);
    cycle(4'd0, 1'b0, 1'b1, rnd(), opc);
    cycle(4'd1, 1'b0, rnd(), rnd(), opc);
    case (opc)
      OP_LW: begin
        cycle(4'd2, 1'b0, rnd(), rnd(), opc);
        for (int i = 0; i < mw; i++) cycle(4'd3, 1'b0, 1'b0, rnd(), opc);
        cycle(4'd3, 1'b0, 1'b1, rnd(), opc);
        cycle(4'd4, 1'b0, rnd(), rnd(), opc);
      end
      OP_SW: begin
        cycle(4'd2, 1'b0, rnd(), rnd(), opc);
        for (int i = 0; i < mw; i++) cycle(4'd5, 1'b0, 1'b0, rnd(), opc);
        cycle(4'd5, 1'b0, 1'b1, rnd(), opc);
      end
      OP_R: begin
        cycle(4'd6, 1'b0, rnd(), rnd(), opc);
        cycle(4'd8, 1'b0, rnd(), rnd(), opc);
      end
      OP_I: begin
        cycle(4'd7, 1'b0, rnd(), rnd(), opc);
        cycle(4'd8, 1'b0, rnd(), rnd(), opc);
      end
      OP_BEQ: cycle(4'd9, 1'b0, rnd(), z, opc);
      default: for (int i = 0; i < 20; i++) cycle(4'd15, 1'b0, rnd(), rnd(), opc);
    endcase
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_pcw;
    int n_done;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    bus.opcode = OP_R;

    // Reset: FETCH with every strobe held low despite mem_ready=1.
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(4'd0, 1'b1, 1'b1, 1'b1, OP_R);

    // R-type: 0,1,6,8 then back to FETCH with instret=1.
    st_log.delete();
    run_instr(OP_R, 1'b0, 0, 0);
    chk("r_len", 32'(st_log.size()), 32'd4);
    if (st_log.size() == 4) begin
      chk("r_st0", 32'(st_log[0]), 32'd0);
      chk("r_st1", 32'(st_log[1]), 32'd1);
      chk("r_st2", 32'(st_log[2]), 32'd6);
      chk("r_st3", 32'(st_log[3]), 32'd8);
    end
    chk("r_next_fetch", 32'(state_o), 32'd0);
    chk("r_instret", instret, 32'd1);

    // I-ALU with one FETCH wait cycle.
    run_instr(OP_I, 1'b0, 1, 0);

    // lw with two MEMREAD waits: 7 cycles, states 0,1,2,3,3,3,4.
    st_log.delete();
    run_instr(OP_LW, 1'b0, 0, 2);
    chk("lw_cycles", 32'(st_log.size()), 32'd7);
    chk("lw_instret", instret, 32'd3);

    // sw with one MEMWRITE wait.
    run_instr(OP_SW, 1'b0, 0, 1);

    // beq taken then not taken.
    n_pcw = 0;
    n_done = 0;
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    chk("beq_instret", instret, 32'd6);

    // lw with no waits: minimum 5 cycles.
    st_log.delete();
    run_instr(OP_LW, 1'b0, 0, 0);
    chk("lw_min_cycles", 32'(st_log.size()), 32'd5);

    // Reset during a MEMWRITE wait: the request drops in the reset cycle.
    cycle(4'd0, 1'b0, 1'b1, 1'b0, OP_SW);
    cycle(4'd1, 1'b0, 1'b0, 1'b0, OP_SW);
    cycle(4'd2, 1'b0, 1'b0, 1'b0, OP_SW);
    cycle(4'd5, 1'b0, 1'b0, 1'b0, OP_SW);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_memwrite_drop", 32'(bus.MemWrite), 32'd0);
    cycle(4'd5, 1'b1, 1'b0, 1'b0, OP_SW);
    chk("rst_instret_clear", instret, 32'd0);
    chk("rst_restart_fetch", 32'(state_o), 32'd0);

    // Counter wrap: preload all-ones, one sw retires to zero.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_inst = 32'hFFFF_FFFF;
    #1;
    chk("wrap_preload", instret, 32'hFFFF_FFFF);
    run_instr(OP_SW, 1'b0, 0, 0);
    chk("wrap_to_zero", instret, 32'd0);

    // Illegal opcode: DECODE then TRAP held 20 cycles, then reset clears.
    run_instr(OP_BAD, 1'b0, 0, 0);
    chk("trap_state", 32'(state_o), 32'd15);
    chk("trap_illegal", 32'(illegal), 32'd1);
    chk("trap_instret_frozen", instret, 32'd0);
    cycle(4'd15, 1'b1, 1'b1, 1'b0, OP_BAD);
    chk("trap_reset_fetch", 32'(state_o), 32'd0);
    chk("trap_reset_illegal", 32'(illegal), 32'd0);

    // Normal operation resumes after leaving TRAP.
    run_instr(OP_R, 1'b0, 2, 0);
    chk("resume_instret", instret, 32'd1);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RISC-V core: sequences fetch, decode, execute, memory and write-back over the shared ALU, register file and unified memory port. Drives the `ALUOp` and function-enable that feed the ALU control decoder, plus every datapath strobe and mux select. It waits on a memory ready handshake, flags illegal opcodes and counts retired instructions.

## Interface
- `INSTRET_W`, 32, width of retired-instruction counter
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  7  IR[6:0], valid from DECODE onward
- `zero`  in  1  ALU zero flag, combinational from current ALU result
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`  out  1  PC register load enable
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemRead`, `MemWrite`  out  1 each  memory request strobes, held until `mem_ready`
- `IRWrite`  out  1  load IR and OldPC
- `RegWrite`  out  1  register file write enable
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1 (reg A)
- `ALUSrcB`  out  2  00 rs2 (reg B), 01 immediate, 10 constant 4
- `ALUOp`  out  2  to ALU control: 00 add/ANDI, 01 sub, 10 R-type
- `AluFunctEn`  out  1  1 = pass IR funct3/funct7 to ALU control; 0 = datapath forces funct3 = 000, funct7 = 0
- `ResultSrc`  out  2  00 ALUOut, 01 memory data reg, 10 ALU result
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction
- `illegal`  out  1  sticky, unsupported opcode
- `state_o`  out  4  current state encoding, for debug
- `instret`  out  INSTRET_W  retired-instruction count

## Operation
- Opcodes:
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 lw
  - 0100011 sw
  - 1100011 beq
  - All others go to TRAP.
- States and encodings, with outputs. Unlisted outputs are 0.
  - FETCH=0
    - `MemRead`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10
    - `IRWrite` = `PCWrite` = `mem_ready`
    - Advance to DECODE on `mem_ready`, else stay.
  - DECODE=1
    - `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00; latches the branch target in ALUOut
    - Next state: lw/sw → MEMADR; R → EXECR; I-ALU → EXECI; beq → BEQ; else TRAP.
  - MEMADR=2
    - `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00
    - Next state: lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD=3
    - `MemRead`=1, `AdrSrc`=1
    - Advance to MEMWB on `mem_ready`.
  - MEMWB=4
    - `ResultSrc`=01, `RegWrite`=1, `instr_done`=1
    - Next state: FETCH.
  - MEMWRITE=5
    - `MemWrite`=1, `AdrSrc`=1
    - `instr_done` = `mem_ready`; advance to FETCH on `mem_ready`.
  - EXECR=6
    - `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10, `AluFunctEn`=1
    - Next state: ALUWB.
  - EXECI=7
    - `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00, `AluFunctEn`=1
    - Next state: ALUWB.
  - ALUWB=8
    - `ResultSrc`=00, `RegWrite`=1, `instr_done`=1
    - Next state: FETCH.
  - BEQ=9
    - `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00
    - `PCWrite` = `zero`, `instr_done`=1
    - Next state: FETCH.
  - TRAP=15
    - All strobes 0, `illegal`=1; no exit except `reset`.
- `AluFunctEn`=0 outside EXECR/EXECI, so a stale IR funct3=111 cannot turn PC+4 or address adds into AND.
- `instret` increments by 1 on every `instr_done` and wraps modulo 2^INSTRET_W.
- Outputs are decoded from the state register plus `mem_ready`/`zero` gating only; there are no other combinational input paths.

## Timing
- Reset behaviour:
  - While `reset`=1, all strobes (`PCWrite`, `IRWrite`, `MemRead`, `MemWrite`, `RegWrite`, `instr_done`) are forced 0.
  - Selects = 0, `ALUOp`=00, `AluFunctEn`=0.
  - State ← FETCH, `instret` ← 0, `illegal` ← 0 at the edge.
  - First cycle after deassertion is FETCH.
- Reset mid-instruction, including during a wait on `mem_ready`: the request drops in the reset cycle and no register or memory write occurs.
- Minimum cycles per instruction with `mem_ready` held 1: lw 5, sw 4, R 4, I-ALU 4, beq 3.
- Each cycle of `mem_ready`=0 in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Request strobes and `AdrSrc` are held stable while waiting.
- `instr_done` never asserts in TRAP; `instret` is frozen there.

## Test plan
- Reset, then `mem_ready`=1, opcode 0110011 → `state_o` sequence 0,1,6,8,0; `ALUOp`=10 with `AluFunctEn`=1 in state 6; `RegWrite`=1 only in state 8; `instret`=1.
- lw with `mem_ready` low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0; `MemRead`=1 and `AdrSrc`=1 stable across the wait; 7 cycles total.
- beq with `zero`=1, then a second beq with `zero`=0 → `PCWrite`=1 in state 9 for the first only; `instr_done` pulses once per beq.
- opcode 0000000 → DECODE then TRAP (15), `illegal`=1 held for 20 cycles, no strobes; `reset` → FETCH, `illegal`=0.
- Assert `reset` in MEMWRITE while `mem_ready`=0 → `MemWrite` drops that cycle, `instret` cleared, restart in FETCH.
- Preload `instret` to 2^32−1 via 2^32−1 retirements (or a force), run one sw → `instret`=0.
